// File: rtl/l2norm_vector_source.sv
// AXI-Stream frame source for the L2-norm engine: sends a stored vector frame, then captures one result beat.
// Optional result watchdog is enabled by defining L2SRC_TIMEOUT_EN.
module l2norm_vector_source #(
  parameter int DATA_W      = 64,
  parameter int RES_W       = 32,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   io_wr_addr,
  input  logic [DATA_W-1:0]          io_wr_data,
  input  logic                       io_start,
  input  logic [$clog2(DEPTH):0]     io_len,
  output logic                       io_busy,
  output logic                       io_done,
  output logic                       io_error,
  output logic [RES_W-1:0]           io_result,
  output logic [DATA_W-1:0]          io_tx_tdata,
  output logic                       io_tx_tvalid,
  output logic                       io_tx_tuser,
  output logic [DATA_W/8-1:0]        io_tx_tkeep,
  input  logic                       io_tx_tready,
  output logic                       io_tx_tlast,
  input  logic [RES_W-1:0]           io_rx_tdata,
  input  logic                       io_rx_tvalid,
  output logic                       io_rx_tready,
  input  logic                       io_rx_tlast
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RES
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               tx_valid;
  logic               tx_fire;
  logic               tx_last_beat;
  logic               len_ok;

`ifdef L2SRC_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
`endif

  assign tx_valid     = (state_q == ST_SEND);
  assign tx_fire      = tx_valid && io_tx_tready;
  assign tx_last_beat = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
  assign len_ok       = (io_len != '0) && (io_len <= LEN_W'(DEPTH));

  // Register file has no reset; writes only land while idle so a frame in flight never sees them.
  always_ff @(posedge clock) begin
    if (io_wr_en && (state_q == ST_IDLE)) begin
      mem[io_wr_addr] <= io_wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    result_d = result_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
`ifdef L2SRC_TIMEOUT_EN
    wdog_d   = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (io_start) begin
          if (len_ok) begin
            len_d   = io_len;
            idx_d   = '0;
            state_d = ST_SEND;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (tx_fire) begin
          if (tx_last_beat) begin
            state_d = ST_WAIT_RES;
`ifdef L2SRC_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      ST_WAIT_RES: begin
        if (io_rx_tvalid) begin
          result_d = io_rx_tdata;
          done_d   = 1'b1;
          error_d  = !io_rx_tlast;
          state_d  = ST_IDLE;
`ifdef L2SRC_TIMEOUT_EN
        end else if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef L2SRC_TIMEOUT_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      result_q <= result_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef L2SRC_TIMEOUT_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  // Beat signals are decoded from state and index, so they are zero whenever no frame is active.
  assign io_tx_tvalid = tx_valid;
  assign io_tx_tdata  = tx_valid ? mem[idx_q] : '0;
  assign io_tx_tuser  = tx_valid && (idx_q == '0);
  assign io_tx_tlast  = tx_valid && tx_last_beat;
  assign io_tx_tkeep  = tx_valid ? '1 : '0;
  assign io_rx_tready = (state_q == ST_WAIT_RES);
  assign io_busy      = (state_q != ST_IDLE);
  assign io_done      = done_q;
  assign io_error     = error_q;
  assign io_result    = result_q;

endmodule

// File: tb/tb_l2norm_vector_source.sv
// Directed bench for l2norm_vector_source: a per-cycle vector table plus hand-written stall, reset and timeout sequences.
module tb_l2norm_vector_source;

  logic        clock;
  logic        reset;
  logic        io_wr_en;
  logic [3:0]  io_wr_addr;
  logic [63:0] io_wr_data;
  logic        io_start;
  logic [4:0]  io_len;
  logic        io_busy;
  logic        io_done;
  logic        io_error;
  logic [31:0] io_result;
  logic [63:0] io_tx_tdata;
  logic        io_tx_tvalid;
  logic        io_tx_tuser;
  logic [7:0]  io_tx_tkeep;
  logic        io_tx_tready;
  logic        io_tx_tlast;
  logic [31:0] io_rx_tdata;
  logic        io_rx_tvalid;
  logic        io_rx_tready;
  logic        io_rx_tlast;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic        start;
    logic [4:0]  len;
    logic        tready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_last;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;
    logic        tvalid;
    logic [63:0] tdata;
    logic        tuser;
    logic        tlast;
    logic        rx_tready;
  } vec_t;

  vec_t vecs [21];

  l2norm_vector_source #(
    .DATA_W(64), .RES_W(32), .DEPTH(16), .TIMEOUT_CYC(8)
  ) dut (
    .clock(clock), .reset(reset),
    .io_wr_en(io_wr_en), .io_wr_addr(io_wr_addr), .io_wr_data(io_wr_data),
    .io_start(io_start), .io_len(io_len),
    .io_busy(io_busy), .io_done(io_done), .io_error(io_error), .io_result(io_result),
    .io_tx_tdata(io_tx_tdata), .io_tx_tvalid(io_tx_tvalid), .io_tx_tuser(io_tx_tuser),
    .io_tx_tkeep(io_tx_tkeep), .io_tx_tready(io_tx_tready), .io_tx_tlast(io_tx_tlast),
    .io_rx_tdata(io_rx_tdata), .io_rx_tvalid(io_rx_tvalid), .io_rx_tready(io_rx_tready),
    .io_rx_tlast(io_rx_tlast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    io_wr_en     = 1'b0;
    io_wr_addr   = '0;
    io_wr_data   = '0;
    io_start     = 1'b0;
    io_len       = '0;
    io_tx_tready = 1'b0;
    io_rx_tvalid = 1'b0;
    io_rx_tdata  = '0;
    io_rx_tlast  = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    io_wr_en     = v.wr_en;
    io_wr_addr   = v.wr_addr;
    io_wr_data   = v.wr_data;
    io_start     = v.start;
    io_len       = v.len;
    io_tx_tready = v.tready;
    io_rx_tvalid = v.rx_valid;
    io_rx_tdata  = v.rx_data;
    io_rx_tlast  = v.rx_last;
  endtask

  task automatic check_row(input int r, input vec_t v);
    check_output($sformatf("r%0d_busy", r),   64'(io_busy),      64'(v.busy));
    check_output($sformatf("r%0d_done", r),   64'(io_done),      64'(v.done));
    check_output($sformatf("r%0d_error", r),  64'(io_error),     64'(v.error));
    check_output($sformatf("r%0d_result", r), 64'(io_result),    64'(v.result));
    check_output($sformatf("r%0d_tvalid", r), 64'(io_tx_tvalid), 64'(v.tvalid));
    check_output($sformatf("r%0d_tdata", r),  io_tx_tdata,       v.tdata);
    check_output($sformatf("r%0d_tuser", r),  64'(io_tx_tuser),  64'(v.tuser));
    check_output($sformatf("r%0d_tlast", r),  64'(io_tx_tlast),  64'(v.tlast));
    check_output($sformatf("r%0d_tkeep", r),  64'(io_tx_tkeep),  v.tvalid ? 64'hFF : 64'h0);
    check_output($sformatf("r%0d_rxready", r), 64'(io_rx_tready), 64'(v.rx_tready));
  endtask

  initial begin
    logic [63:0] exp_beat [4];
    int beats;

    //           wr  addr data    st len  rdy rxv rxdata  rxl | busy done err result  tv tdata   tu tl rxr
    vecs[0]  = '{1, 0, 64'h1,  0, 0,  0, 0, 32'h0,  0,  0, 0, 0, 32'h0,  0, 64'h0, 0, 0, 0};
    vecs[1]  = '{1, 1, 64'h2,  0, 0,  0, 0, 32'h0,  0,  0, 0, 0, 32'h0,  0, 64'h0, 0, 0, 0};
    vecs[2]  = '{1, 2, 64'h3,  1, 3,  1, 0, 32'h0,  0,  1, 0, 0, 32'h0,  1, 64'h1, 1, 0, 0};
    vecs[3]  = '{0, 0, 64'h0,  0, 0,  1, 0, 32'h0,  0,  1, 0, 0, 32'h0,  1, 64'h2, 0, 0, 0};
    vecs[4]  = '{0, 0, 64'h0,  0, 0,  1, 0, 32'h0,  0,  1, 0, 0, 32'h0,  1, 64'h3, 0, 1, 0};
    vecs[5]  = '{0, 0, 64'h0,  0, 0,  1, 0, 32'h0,  0,  1, 0, 0, 32'h0,  0, 64'h0, 0, 0, 1};
    vecs[6]  = '{0, 0, 64'h0,  0, 0,  0, 1, 32'h19, 1,  0, 1, 0, 32'h19, 0, 64'h0, 0, 0, 0};
    vecs[7]  = '{0, 0, 64'h0,  0, 0,  0, 0, 32'h0,  0,  0, 0, 0, 32'h19, 0, 64'h0, 0, 0, 0};
    vecs[8]  = '{0, 0, 64'h0,  1, 0,  1, 0, 32'h0,  0,  0, 0, 1, 32'h19, 0, 64'h0, 0, 0, 0};
    vecs[9]  = '{0, 0, 64'h0,  1, 17, 1, 0, 32'h0,  0,  0, 0, 1, 32'h19, 0, 64'h0, 0, 0, 0};
    vecs[10] = '{0, 0, 64'h0,  0, 0,  0, 0, 32'h0,  0,  0, 0, 0, 32'h19, 0, 64'h0, 0, 0, 0};
    vecs[11] = '{0, 0, 64'h0,  1, 1,  0, 0, 32'h0,  0,  1, 0, 0, 32'h19, 1, 64'h1, 1, 1, 0};
    vecs[12] = '{1, 0, 64'hAA, 1, 2,  0, 0, 32'h0,  0,  1, 0, 0, 32'h19, 1, 64'h1, 1, 1, 0};
    vecs[13] = '{0, 0, 64'h0,  0, 0,  1, 0, 32'h0,  0,  1, 0, 0, 32'h19, 0, 64'h0, 0, 0, 1};
    vecs[14] = '{1, 1, 64'hBB, 1, 3,  0, 0, 32'h0,  0,  1, 0, 0, 32'h19, 0, 64'h0, 0, 0, 1};
    vecs[15] = '{0, 0, 64'h0,  0, 0,  0, 1, 32'h7,  0,  0, 1, 1, 32'h7,  0, 64'h0, 0, 0, 0};
    vecs[16] = '{0, 0, 64'h0,  1, 2,  0, 0, 32'h0,  0,  1, 0, 0, 32'h7,  1, 64'h1, 1, 0, 0};
    vecs[17] = '{0, 0, 64'h0,  0, 0,  1, 1, 32'h99, 1,  1, 0, 0, 32'h7,  1, 64'h2, 0, 1, 0};
    vecs[18] = '{0, 0, 64'h0,  0, 0,  1, 1, 32'h99, 1,  1, 0, 0, 32'h7,  0, 64'h0, 0, 0, 1};
    vecs[19] = '{0, 0, 64'h0,  0, 0,  0, 1, 32'h99, 1,  0, 1, 0, 32'h99, 0, 64'h0, 0, 0, 0};
    vecs[20] = '{0, 0, 64'h0,  0, 0,  0, 0, 32'h0,  0,  0, 0, 0, 32'h99, 0, 64'h0, 0, 0, 0};

    set_idle();
    reset = 1'b0;
    step();
    step();
    check_output("reset_busy",   64'(io_busy),      64'h0);
    check_output("reset_tvalid", 64'(io_tx_tvalid), 64'h0);
    check_output("reset_result", 64'(io_result),    64'h0);
    check_output("reset_rxready", 64'(io_rx_tready), 64'h0);
    #2 reset = 1'b1;
    step();

    $display("[TB] vector table");
    for (int r = 0; r < 21; r++) begin
      apply_stimulus(vecs[r]);
      step();
      check_row(r, vecs[r]);
    end
    set_idle();

    $display("[TB] stalled frame of four beats");
    exp_beat[0] = 64'h10;
    exp_beat[1] = 64'h20;
    exp_beat[2] = 64'h30;
    exp_beat[3] = 64'h40;
    for (int i = 0; i < 4; i++) begin
      io_wr_en   = 1'b1;
      io_wr_addr = 4'(i);
      io_wr_data = exp_beat[i];
      step();
    end
    io_wr_en = 1'b0;
    io_start = 1'b1;
    io_len   = 5'd4;
    step();
    io_start = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      check_output($sformatf("stall_c%0d_tvalid", c), 64'(io_tx_tvalid), 64'h1);
      check_output($sformatf("stall_c%0d_tdata", c),  io_tx_tdata, exp_beat[beats]);
      check_output($sformatf("stall_c%0d_tuser", c),  64'(io_tx_tuser), 64'(beats == 0));
      check_output($sformatf("stall_c%0d_tlast", c),  64'(io_tx_tlast), 64'(beats == 3));
      io_tx_tready = (c % 2 == 0);
      if (io_tx_tready) beats++;
      step();
    end
    io_tx_tready = 1'b0;
    check_output("stall_beat_count", 64'(beats), 64'd4);
    check_output("stall_end_tvalid", 64'(io_tx_tvalid), 64'h0);
    check_output("stall_end_rxready", 64'(io_rx_tready), 64'h1);
    io_rx_tvalid = 1'b1;
    io_rx_tdata  = 32'h2A;
    io_rx_tlast  = 1'b1;
    step();
    set_idle();
    check_output("stall_done", 64'(io_done), 64'h1);
    check_output("stall_result", 64'(io_result), 64'h2A);

    $display("[TB] reset in the middle of a frame");
    io_start     = 1'b1;
    io_len       = 5'd3;
    io_tx_tready = 1'b1;
    step();
    io_start = 1'b0;
    step();
    step();
    check_output("midrst_pre_tdata", io_tx_tdata, 64'h30);
    io_tx_tready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_output("midrst_tvalid", 64'(io_tx_tvalid), 64'h0);
    check_output("midrst_tdata",  io_tx_tdata, 64'h0);
    check_output("midrst_tlast",  64'(io_tx_tlast), 64'h0);
    check_output("midrst_busy",   64'(io_busy), 64'h0);
    check_output("midrst_result", 64'(io_result), 64'h0);
    check_output("midrst_tkeep",  64'(io_tx_tkeep), 64'h0);
    @(posedge clock);
    #3 reset = 1'b1;
    io_start     = 1'b1;
    io_len       = 5'd2;
    io_tx_tready = 1'b1;
    step();
    io_start = 1'b0;
    check_output("postrst_b0_tdata", io_tx_tdata, 64'h10);
    check_output("postrst_b0_tuser", 64'(io_tx_tuser), 64'h1);
    check_output("postrst_b0_tlast", 64'(io_tx_tlast), 64'h0);
    step();
    check_output("postrst_b1_tdata", io_tx_tdata, 64'h20);
    check_output("postrst_b1_tuser", 64'(io_tx_tuser), 64'h0);
    check_output("postrst_b1_tlast", 64'(io_tx_tlast), 64'h1);
    step();
    io_tx_tready = 1'b0;
    check_output("postrst_wait_rxready", 64'(io_rx_tready), 64'h1);
    io_rx_tvalid = 1'b1;
    io_rx_tdata  = 32'h33;
    io_rx_tlast  = 1'b1;
    step();
    set_idle();
    check_output("postrst_done", 64'(io_done), 64'h1);

`ifdef L2SRC_TIMEOUT_EN
    $display("[TB] result watchdog");
    io_start     = 1'b1;
    io_len       = 5'd1;
    io_tx_tready = 1'b1;
    step();
    io_start = 1'b0;
    step();
    io_tx_tready = 1'b0;
    check_output("wdog_entry_rxready", 64'(io_rx_tready), 64'h1);
    for (int k = 1; k < 8; k++) begin
      step();
      check_output($sformatf("wdog_k%0d_error", k), 64'(io_error), 64'h0);
      check_output($sformatf("wdog_k%0d_busy", k),  64'(io_busy),  64'h1);
    end
    step();
    check_output("wdog_error",  64'(io_error),  64'h1);
    check_output("wdog_done",   64'(io_done),   64'h0);
    check_output("wdog_busy",   64'(io_busy),   64'h0);
    check_output("wdog_result", 64'(io_result), 64'h33);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
